// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, ROM enable levels and the FIFO entry layout.
package inst_fetch_pkg;

  localparam int unsigned InstAddrBus    = 32;
  localparam int unsigned InstBus        = 32;
  localparam int unsigned InstFetchDepth = 2;

  localparam logic [InstBus-1:0] ZeroWord    = '0;
  localparam logic               ChipEnable  = 1'b1;
  localparam logic               ChipDisable = 1'b0;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return a & {{(InstAddrBus-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO between ROM capture and decode; flush dominates push/pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Push while full overwrites the head slot, which is being popped this cycle.
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch initiator: owns the PC, drives the ROM read port and queues {pc, inst} toward decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned            DEPTH    = InstFetchDepth
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   rom_ce,
  output logic [InstAddrBus-1:0] rom_addr,
  input  logic [InstBus-1:0]     rom_inst,
  input  logic                   redirect_valid,
  input  logic [InstAddrBus-1:0] redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                   en_q, en_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [CW-1:0]          count;
  logic                   pop, fire, flush;
  fetch_entry_t           push_entry, head;

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;

  always_comb begin
    flush = en_q & redirect_valid;
    fire  = en_q & ~redirect_valid & ((count < CW'(DEPTH)) | pop);
    en_d  = 1'b1;
    pc_d  = pc_q;
    if (flush) begin
      pc_d = word_align(redirect_pc);
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      en_q <= en_d;
      pc_q <= pc_d;
    end
  end

  assign push_entry = '{pc: pc_q, inst: rom_inst};

  // A pop in a redirect cycle is accepted by decode but discarded by the flush.
  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  assign rom_ce   = fire ? ChipEnable : ChipDisable;
  assign rom_addr = pc_q;
  assign id_pc    = head.pc;
  assign id_inst  = head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed table, corner sequences and random traffic vs a queue model.
module tb_inst_fetch;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ROM_XOR  = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  assign rom_inst = rom_addr ^ ROM_XOR;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ce;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] hpc;
  } vec_t;

  vec_t tbl[13];
  vec_t cur;
  bit   cur_on;

  int checks = 0;
  int errors = 0;

  bit          m_en;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  logic [31:0] dut_pops[$];
  logic [31:0] dut_addrs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rv, input logic [31:0] rpc, input bit rdy,
                              input bit ce, input logic [31:0] addr, input bit vld,
                              input logic [31:0] hpc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ce = ce; v.addr = addr; v.vld = vld; v.hpc = hpc;
    return v;
  endfunction

  task automatic model_reset();
    m_en = 1'b0;
    m_pc = RESET_PC;
    m_q.delete();
  endtask

  // Inputs are driven just after a rising edge; outputs are compared at the falling edge.
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop;
    bit fire;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(negedge clk);
    pop  = (m_q.size() != 0) && rdy;
    fire = m_en && !rv && ((m_q.size() < DEPTH) || pop);
    chk("rom_ce", 32'(rom_ce), 32'(fire));
    chk("rom_addr", rom_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("id_pc", id_pc, m_q[0][63:32]);
      chk("id_inst", id_inst, m_q[0][31:0]);
    end
    if (cur_on) begin
      chk("tbl_ce", 32'(rom_ce), 32'(cur.ce));
      chk("tbl_addr", rom_addr, cur.addr);
      chk("tbl_valid", 32'(id_valid), 32'(cur.vld));
      if (cur.vld) begin
        chk("tbl_pc", id_pc, cur.hpc);
        chk("tbl_inst", id_inst, cur.hpc ^ ROM_XOR);
      end
    end
    if (rom_ce) dut_addrs.push_back(rom_addr);
    if (id_valid && rdy) dut_pops.push_back(id_pc);
    if (m_en && rv) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (fire) begin
        m_q.push_back({m_pc, m_pc ^ ROM_XOR});
        m_pc = m_pc + 32'd4;
      end
    end
    m_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ce"}, 32'(rom_ce), 32'd0);
    chk({tag, "_addr"}, rom_addr, RESET_PC);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_pc"}, id_pc, 32'd0);
    chk({tag, "_inst"}, id_inst, 32'd0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    for (int i = 0; i < 13; i++) begin
      cur    = tbl[i];
      cur_on = 1'b1;
      cycle(cur.rv, cur.rpc, cur.rdy);
    end
    cur_on = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_wrap[3];
    logic [31:0] exp_pops[3];
    int          fires;

    // First row: redirect on the reset-release edge must be ignored.
    tbl[0]  = mk(1, 32'h40,  1, 0, 32'h00,  0, 32'h0);
    tbl[1]  = mk(0, 32'h0,   1, 1, 32'h00,  0, 32'h0);
    tbl[2]  = mk(0, 32'h0,   1, 1, 32'h04,  1, 32'h00);
    tbl[3]  = mk(0, 32'h0,   1, 1, 32'h08,  1, 32'h04);
    tbl[4]  = mk(0, 32'h0,   1, 1, 32'h0C,  1, 32'h08);
    tbl[5]  = mk(0, 32'h0,   0, 1, 32'h10,  1, 32'h0C);
    tbl[6]  = mk(0, 32'h0,   0, 0, 32'h14,  1, 32'h0C);
    tbl[7]  = mk(0, 32'h0,   0, 0, 32'h14,  1, 32'h0C);
    tbl[8]  = mk(0, 32'h0,   1, 1, 32'h14,  1, 32'h0C);
    tbl[9]  = mk(0, 32'h0,   1, 1, 32'h18,  1, 32'h10);
    tbl[10] = mk(1, 32'h103, 1, 0, 32'h1C,  1, 32'h14);
    tbl[11] = mk(0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    tbl[12] = mk(0, 32'h0,   1, 1, 32'h104, 1, 32'h100);
    cur_on  = 1'b0;

    do_reset();
    run_table();

    // Decode stalled for 5 cycles right after reset.
    do_reset();
    cycle(0, 32'h0, 0);
    dut_addrs.delete();
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 0);
    fires = dut_addrs.size();
    chk("stall_pushes", 32'(fires), 32'd2);
    chk("stall_hold_pc", rom_addr, 32'h8);
    dut_pops.delete();
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 1);
    exp_pops[0] = 32'h0; exp_pops[1] = 32'h4; exp_pops[2] = 32'h8;
    chk("stall_pop_n", 32'(dut_pops.size()), 32'd3);
    if (dut_pops.size() >= 3)
      for (int i = 0; i < 3; i++) chk("stall_pop_order", dut_pops[i], exp_pops[i]);

    // Address wrap at the top of the space.
    cycle(1, 32'hFFFF_FFF8, 1);
    dut_addrs.delete();
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 1);
    exp_wrap[0] = 32'hFFFF_FFF8; exp_wrap[1] = 32'hFFFF_FFFC; exp_wrap[2] = 32'h0000_0000;
    chk("wrap_n", 32'(dut_addrs.size()), 32'd3);
    if (dut_addrs.size() >= 3)
      for (int i = 0; i < 3; i++) chk("wrap_addr", dut_addrs[i], exp_wrap[i]);

    // Asynchronous reset mid-stream, then the first scenario again.
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("async_hold");
    rst_n = 1'b1;
    run_table();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      cycle(rv, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
